// File: rtl/rom_seq_reader_if.sv
// rtl/rom_seq_reader_if.sv - command, ROM bus and byte-stream signals of the ROM sequential reader
// Optional checksum signal present when ROM_SEQ_READER_CHECKSUM_EN is defined.
interface rom_seq_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 6
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
        input  start, start_addr, count, rom_data, out_ready,
        output busy, done, rom_addr, rom_read_en, out_data, out_valid, out_last
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, start_addr, count, rom_data, out_ready,
        input  busy, done, rom_addr, rom_read_en, out_data, out_valid, out_last
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/rom_seq_reader.sv
// rtl/rom_seq_reader.sv - sequences ROM reads for a burst and streams each byte out with a last marker
// Optional byte checksum output enabled by ROM_SEQ_READER_CHECKSUM_EN.
module rom_seq_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic rst,
    rom_seq_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** ADDR_W);

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [CNT_W-1:0]  r_rem, w_rem_nx;
    logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nx;
    logic              r_rom_read_en, w_rom_read_en_nx;
    logic [DATA_W-1:0] r_out_data, w_out_data_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic              r_out_last, w_out_last_nx;
    logic              r_done, w_done_nx;
    logic              r_busy, w_busy_nx;
    logic [CNT_W-1:0]  w_count_sat;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum, w_checksum_nx;
`endif

    assign w_count_sat = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_rom_addr    <= '0;
            r_rom_read_en <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
            r_checksum    <= '0;
`endif
        end else begin
            r_state       <= w_state_nx;
            r_addr        <= w_addr_nx;
            r_rem         <= w_rem_nx;
            r_rom_addr    <= w_rom_addr_nx;
            r_rom_read_en <= w_rom_read_en_nx;
            r_out_data    <= w_out_data_nx;
            r_out_valid   <= w_out_valid_nx;
            r_out_last    <= w_out_last_nx;
            r_done        <= w_done_nx;
            r_busy        <= w_busy_nx;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
            r_checksum    <= w_checksum_nx;
`endif
        end
    end

    // Every output is the registered image of its next value, so the strobes
    // are asserted on the edge that enters the state they belong to.
    always_comb begin
        w_state_nx       = r_state;
        w_addr_nx        = r_addr;
        w_rem_nx         = r_rem;
        w_rom_addr_nx    = r_rom_addr;
        w_rom_read_en_nx = 1'b0;
        w_out_data_nx    = r_out_data;
        w_out_valid_nx   = r_out_valid;
        w_out_last_nx    = r_out_last;
        w_done_nx        = 1'b0;
        w_busy_nx        = r_busy;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        w_checksum_nx    = r_checksum;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_busy_nx = 1'b1;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
                    w_checksum_nx = '0;
`endif
                    if (bus.count == '0) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx       = S_FETCH;
                        w_addr_nx        = bus.start_addr;
                        w_rem_nx         = w_count_sat;
                        w_rom_addr_nx    = bus.start_addr;
                        w_rom_read_en_nx = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_state_nx     = S_HOLD;
                w_out_data_nx  = bus.rom_data;
                w_out_valid_nx = 1'b1;
                w_out_last_nx  = (r_rem == CNT_W'(1));
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_out_last_nx  = 1'b0;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
                    w_checksum_nx  = r_checksum + r_out_data;
`endif
                    if (r_out_last) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx       = S_FETCH;
                        w_addr_nx        = r_addr + 1'b1;
                        w_rem_nx         = r_rem - 1'b1;
                        w_rom_addr_nx    = r_addr + 1'b1;
                        w_rom_read_en_nx = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.rom_addr    = r_rom_addr;
    assign bus.rom_read_en = r_rom_read_en;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
    assign bus.checksum    = r_checksum;
`endif
endmodule

// File: tb/tb_rom_seq_reader.sv
// tb/tb_rom_seq_reader.sv - self-checking bench for rom_seq_reader against a burst-level byte model
module tb_rom_seq_reader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rom [32];

    always #5 clk = ~clk;

    rom_seq_reader_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(6)) bus ();

    rom_seq_reader #(.ADDR_W(5), .DATA_W(8), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({tag, "_rom_read_en"}, 32'(bus.rom_read_en), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
`endif
    endtask

    // mode 0: ready always high; 1: random ready plus stray start pulses; 2: ready low for 5 valid cycles first
    task automatic run_burst(input int a, input int cnt, input int mode);
        logic [7:0] exp_q [$];
        int   n;
        int   idx = 0;
        int   fetch = 0;
        int   hold = 0;
        int   sum = 0;
        bit   seen_done = 0;
        bit   have_addr = 0;
        bit   prev_stall = 0;
        bit   rdy;
        logic [4:0] last_addr = '0;
        n = (cnt > 32) ? 32 : cnt;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rom[(a + i) % 32]);
            sum += int'(rom[(a + i) % 32]);
        end
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = a[4:0];
        bus.count      = cnt[5:0];
        bus.out_ready  = 1'b0;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.start_addr = 5'($urandom);
        bus.count      = 6'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("first_read_en", 32'(bus.rom_read_en), 32'(n != 0));
        check("zero_count_done", 32'(bus.done), 32'(n == 0));
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check("ren_while_valid", 32'(bus.rom_read_en & bus.out_valid), 32'd0);
            if (prev_stall) check("valid_held", 32'(bus.out_valid), 32'd1);
            if (bus.rom_read_en) begin
                check("rom_addr", 32'(bus.rom_addr), 32'((a + fetch) % 32));
                last_addr = bus.rom_addr;
                have_addr = 1;
                fetch++;
            end else if (have_addr) begin
                check("rom_addr_hold", 32'(bus.rom_addr), 32'(last_addr));
            end
            if (bus.done) begin
                check("bytes_at_done", 32'(idx), 32'(n));
`ifdef ROM_SEQ_READER_CHECKSUM_EN
                check("checksum", 32'(bus.checksum), 32'(sum % 256));
`endif
                seen_done = 1;
            end
            case (mode)
                1:       rdy = 1'($urandom);
                2:       rdy = (hold >= 5);
                default: rdy = 1'b1;
            endcase
            bus.out_ready = rdy;
            if (mode == 1) bus.start = ($urandom % 4 == 0);
            if (bus.out_valid) begin
                if (mode == 2 && hold < 5) hold++;
                check("byte_overrun", 32'(idx < n), 32'd1);
                if (idx < n) begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q[idx]));
                    check("out_last", 32'(bus.out_last), 32'(idx == n - 1));
                end
                if (rdy) idx++;
            end
            prev_stall = bus.out_valid && !rdy;
        end
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        check("fetch_count", 32'(fetch), 32'(n));
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_cleared", 32'(bus.busy), 32'd0);
        check("valid_after_done", 32'(bus.out_valid), 32'd0);
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        check("checksum_stable", 32'(bus.checksum), 32'(sum % 256));
`endif
    endtask

    initial begin
        bit got_valid = 0;
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        bus.out_ready  = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_burst(0, 1, 0);
        run_burst(7, 2, 0);
        run_burst(30, 4, 0);
        run_burst(20, 3, 2);
        run_burst(5, 0, 0);
        run_burst(12, 5, 1);
        run_burst(0, 32, 0);
        run_burst(0, 40, 1);
        for (int k = 0; k < 12; k++) run_burst(int'($urandom % 32), int'($urandom % 41), 1);

        // Asynchronous reset while a byte is held on the output
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = 5'd20;
        bus.count      = 6'd3;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 10 && !got_valid; c++) begin
            @(negedge clk);
            got_valid = bus.out_valid;
        end
        check("hold_reached", 32'(got_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(bus.done), 32'd0);
            check("idle_after_rst", 32'(bus.busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
